// File: rtl/vga_fb_arbiter_if.sv
// vga_fb_arbiter_if: scanout, CPU and RAM-port signals of the framebuffer arbiter
interface vga_fb_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
);
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic [DATA_W-1:0] vga_rdata;
  logic              vga_rvalid;
  logic              cpu_valid;
  logic              cpu_ready;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [2:0]        wr_level;
  modport slave (
    input  vga_req, vga_addr, cpu_valid, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    output vga_rdata, vga_rvalid, cpu_ready, cpu_rdata, cpu_rvalid,
           ram_addr, ram_we, ram_wdata, wr_level
  );
  modport master (
    output vga_req, vga_addr, cpu_valid, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    input  vga_rdata, vga_rvalid, cpu_ready, cpu_rdata, cpu_rvalid,
           ram_addr, ram_we, ram_wdata, wr_level
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: single-port framebuffer RAM shared by never-stalling scanout and a posted-write CPU port
module vga_fb_arbiter #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
) (
  input logic             CLOCK_50,
  input logic             RESET_N,
  vga_fb_arbiter_if.slave bus
);
  typedef enum logic [1:0] {SLOT_IDLE, SLOT_VGA, SLOT_DRAIN, SLOT_CPU} slot_e;
  localparam int EW = ADDR_W + DATA_W;
  slot_e             slot;
  logic              ready, acc, push, pop;
  logic [EW-1:0]     fifo_q [4];
  logic [EW-1:0]     fifo_d [4];
  logic [1:0]        wp_q, wp_d, rp_q, rp_d;
  logic [2:0]        lvl_q, lvl_d;
  logic              pend_q, pend_d, alive_q, alive_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              vga_p1_q, vga_p1_d, vga_p2_q, vga_p2_d;
  logic              cpu_p1_q, cpu_p1_d, cpu_p2_q, cpu_p2_d;
  logic [DATA_W-1:0] cpu_hold_q, cpu_hold_d;
  // Slot choice (scanout > drain > pending read), write posting and the two-stage read-return pipes
  always_comb begin
    slot = bus.vga_req ? SLOT_VGA : lvl_q != 3'd0 ? SLOT_DRAIN : pend_q ? SLOT_CPU : SLOT_IDLE;
    ready = alive_q && !pend_q && (!bus.cpu_we || lvl_q != 3'd4);
    acc = bus.cpu_valid && ready;
    push = acc && bus.cpu_we;
    pop = slot == SLOT_DRAIN;
    fifo_d = fifo_q;
    if (push) fifo_d[wp_q] = {bus.cpu_addr, bus.cpu_wdata};
    wp_d = wp_q + 2'(push);
    rp_d = rp_q + 2'(pop);
    lvl_d = lvl_q + 3'(push) - 3'(pop);
    alive_d = 1'b1;
    pend_d = (acc && !bus.cpu_we) || (pend_q && slot != SLOT_CPU);
    pend_addr_d = (acc && !bus.cpu_we) ? bus.cpu_addr : pend_addr_q;
    ram_addr_d = slot == SLOT_VGA ? bus.vga_addr :
                 slot == SLOT_DRAIN ? fifo_q[rp_q][EW-1:DATA_W] :
                 slot == SLOT_CPU ? pend_addr_q : ram_addr_q;
    ram_wdata_d = pop ? fifo_q[rp_q][DATA_W-1:0] : ram_wdata_q;
    ram_we_d = pop;
    vga_p1_d = slot == SLOT_VGA;
    vga_p2_d = vga_p1_q;
    cpu_p1_d = slot == SLOT_CPU;
    cpu_p2_d = cpu_p1_q;
    cpu_hold_d = cpu_p2_q ? bus.ram_rdata : cpu_hold_q;
  end
  // State registers; reset empties the FIFO and drops every in-flight request
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      fifo_q      <= '{default: '0};
      wp_q        <= '0;
      rp_q        <= '0;
      lvl_q       <= '0;
      alive_q     <= 1'b0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      vga_p1_q    <= 1'b0;
      vga_p2_q    <= 1'b0;
      cpu_p1_q    <= 1'b0;
      cpu_p2_q    <= 1'b0;
      cpu_hold_q  <= '0;
    end else begin
      fifo_q      <= fifo_d;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      lvl_q       <= lvl_d;
      alive_q     <= alive_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      vga_p1_q    <= vga_p1_d;
      vga_p2_q    <= vga_p2_d;
      cpu_p1_q    <= cpu_p1_d;
      cpu_p2_q    <= cpu_p2_d;
      cpu_hold_q  <= cpu_hold_d;
    end
  end
  assign bus.cpu_ready  = ready;
  assign bus.vga_rvalid = vga_p2_q;
  assign bus.vga_rdata  = vga_p2_q ? bus.ram_rdata : '0;
  assign bus.cpu_rvalid = cpu_p2_q;
  assign bus.cpu_rdata  = cpu_p2_q ? bus.ram_rdata : cpu_hold_q;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_we     = ram_we_q;
  assign bus.ram_wdata  = ram_wdata_q;
  assign bus.wr_level   = lvl_q;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: directed stimulus with a transaction-level reference model checked every cycle
module tb_vga_fb_arbiter;
  typedef struct packed {logic [18:0] a; logic [7:0] d;} wr_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  int we_cnt = 0;
  logic [7:0] mem [1024];
  logic [7:0] shadow [1024];
  wr_t wq [$];
  bit pend, alive;
  logic [18:0] pa, e_addr;
  logic [7:0] pd, e_wdata, vd1, vd2, cd1, cd2, hold;
  bit e_we, v1, v2, c1, c2;
  vga_fb_arbiter_if #(.ADDR_W(19), .DATA_W(8)) bus ();
  vga_fb_arbiter #(.ADDR_W(19), .DATA_W(8)) dut (.CLOCK_50(clk), .RESET_N(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  // Synchronous single-port RAM, read-first
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr[9:0]] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr[9:0]];
  end
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  // Data a CPU read must return: newest still-posted write to that address, else RAM contents
  function automatic logic [7:0] lookup(input logic [18:0] a);
    logic [7:0] r = shadow[a[9:0]];
    foreach (wq[i]) if (wq[i].a == a) r = wq[i].d;
    return r;
  endfunction
  // Reference model: which access owns each cycle, and what each return must carry
  always @(posedge clk or negedge rst_n) begin
    bit rdy, acc;
    wr_t w;
    if (!rst_n) begin
      wq.delete();
      {pend, alive, e_we, v1, v2, c1, c2} = '0;
      {pa, e_addr, pd, e_wdata, vd1, vd2, cd1, cd2, hold} = '0;
    end else begin
      rdy = alive && !pend && (!bus.cpu_we || wq.size() < 4);
      acc = bus.cpu_valid && rdy;
      alive = 1;
      if (c2) hold = cd2;
      v2 = v1; vd2 = vd1; c2 = c1; cd2 = cd1;
      v1 = 0; c1 = 0; e_we = 0;
      if (bus.vga_req) begin
        e_addr = bus.vga_addr; v1 = 1; vd1 = shadow[bus.vga_addr[9:0]];
      end else if (wq.size() > 0) begin
        w = wq.pop_front();
        e_addr = w.a; e_wdata = w.d; e_we = 1; shadow[w.a[9:0]] = w.d;
      end else if (pend) begin
        e_addr = pa; c1 = 1; cd1 = pd; pend = 0;
      end
      if (acc && bus.cpu_we) wq.push_back({bus.cpu_addr, bus.cpu_wdata});
      else if (acc) begin
        pend = 1; pa = bus.cpu_addr; pd = lookup(bus.cpu_addr);
      end
    end
  end
  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (bus.ram_we === 1'b1) we_cnt++;
    chk("wr_level", 32'(bus.wr_level), 32'(wq.size()));
    chk("ram_we", 32'(bus.ram_we), 32'(e_we));
    chk("ram_addr", 32'(bus.ram_addr), 32'(e_addr));
    chk("ram_wdata", 32'(bus.ram_wdata), 32'(e_wdata));
    chk("vga_rvalid", 32'(bus.vga_rvalid), 32'(v2));
    chk("vga_rdata", 32'(bus.vga_rdata), v2 ? 32'(vd2) : 32'd0);
    chk("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(c2));
    chk("cpu_rdata", 32'(bus.cpu_rdata), c2 ? 32'(cd2) : 32'(hold));
    chk("cpu_ready", 32'(bus.cpu_ready), 32'(alive && !pend && (!bus.cpu_we || wq.size() < 4)));
  end
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic idle(input int n);
    bus.vga_req = 0;
    bus.cpu_valid = 0;
    repeat (n) tick();
  endtask
  task automatic cpu_op(input logic we, input logic [18:0] a, input logic [7:0] d, output int waits);
    bit ok = 0;
    bus.cpu_valid = 1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
    waits = 0;
    for (int i = 0; i < 64 && !ok; i++) begin
      #1;
      ok = bus.cpu_ready;
      @(posedge clk);
      #2;
      if (!ok) waits++;
    end
    if (!ok) chk("handshake_timeout", 0, 1);
    bus.cpu_valid = 0;
  endtask
  task automatic wait_cpu_rvalid(input string n, input logic [7:0] exp);
    bit seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      #1;
      seen = bus.cpu_rvalid;
      if (seen) chk(n, 32'(bus.cpu_rdata), 32'(exp));
      else begin
        @(posedge clk);
        #2;
      end
    end
    if (!seen) chk({n, "_timeout"}, 0, 1);
  endtask
  task automatic do_reset();
    idle(0);
    @(negedge clk);
    #1 rst_n = 0;
    #1;
    chk("rst_wr_level", 32'(bus.wr_level), 0);
    chk("rst_ram_we", 32'(bus.ram_we), 0);
    chk("rst_ram_addr", 32'(bus.ram_addr), 0);
    chk("rst_vga_rvalid", 32'(bus.vga_rvalid), 0);
    chk("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 0);
    chk("rst_cpu_ready", 32'(bus.cpu_ready), 0);
    chk("rst_cpu_rdata", 32'(bus.cpu_rdata), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    tick();
  endtask
  initial begin
    int w, base;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 8'(i) ^ 8'hC3;
      shadow[i] = 8'(i) ^ 8'hC3;
    end
    mem[100] = 8'h5A;
    shadow[100] = 8'h5A;
    bus.vga_req = 0; bus.vga_addr = 0;
    bus.cpu_valid = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
    #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    tick();
    // Four posted writes with idle scanout
    base = we_cnt;
    for (int i = 0; i < 4; i++) begin
      cpu_op(1, 19'(i), 8'hA0 + 8'(i), w);
      chk("post_wait", 32'(w), 0);
    end
    idle(6);
    chk("post_level", 32'(bus.wr_level), 0);
    chk("post_we_cnt", 32'(we_cnt - base), 4);
    // Full FIFO while scanout hogs the port
    base = we_cnt;
    bus.vga_req = 1; bus.vga_addr = 600;
    for (int i = 0; i < 4; i++) begin
      cpu_op(1, 19'(10 + i), 8'hB0 + 8'(i), w);
      bus.vga_addr = bus.vga_addr + 1;
    end
    bus.cpu_valid = 1; bus.cpu_we = 1; bus.cpu_addr = 14; bus.cpu_wdata = 8'hB4;
    #1;
    chk("full_level", 32'(bus.wr_level), 4);
    chk("full_ready", 32'(bus.cpu_ready), 0);
    tick();
    tick();
    #1 chk("full_ready_held", 32'(bus.cpu_ready), 0);
    bus.vga_req = 0;
    cpu_op(1, 14, 8'hB4, w);
    idle(8);
    chk("full_we_cnt", 32'(we_cnt - base), 5);
    chk("full_drained", 32'(bus.wr_level), 0);
    // Scanout latency with a CPU write in the same cycle
    bus.vga_req = 1; bus.vga_addr = 100;
    bus.cpu_valid = 1; bus.cpu_we = 1; bus.cpu_addr = 500; bus.cpu_wdata = 8'h77;
    tick();
    bus.vga_req = 0; bus.cpu_valid = 0;
    #1 chk("lat_early", 32'(bus.vga_rvalid), 0);
    tick();
    #1;
    chk("lat_rvalid", 32'(bus.vga_rvalid), 1);
    chk("lat_rdata", 32'(bus.vga_rdata), 32'h5A);
    idle(4);
    // Plain CPU read of initial RAM contents
    cpu_op(0, 40, 0, w);
    wait_cpu_rvalid("rd_plain", 8'hEB);
    idle(2);
    // Read-after-write behind ten cycles of scanout
    bus.vga_req = 1; bus.vga_addr = 300;
    cpu_op(1, 7, 8'h33, w);
    bus.vga_addr = 301;
    cpu_op(0, 7, 0, w);
    #1 chk("raw_pend_ready", 32'(bus.cpu_ready), 0);
    for (int i = 0; i < 8; i++) begin
      bus.vga_addr = 19'(302 + i);
      tick();
    end
    bus.vga_req = 0;
    wait_cpu_rvalid("raw_rdata", 8'h33);
    idle(3);
    chk("raw_hold", 32'(bus.cpu_rdata), 32'h33);
    chk("raw_pulse", 32'(bus.cpu_rvalid), 0);
    // Reset in the middle of draining
    base = we_cnt;
    bus.vga_req = 1; bus.vga_addr = 700;
    for (int i = 0; i < 3; i++) cpu_op(1, 19'(20 + i), 8'hC0 + 8'(i), w);
    chk("mid_level", 32'(bus.wr_level), 3);
    bus.vga_req = 0;
    tick();
    do_reset();
    idle(6);
    chk("mid_we_cnt", 32'(we_cnt - base), 1);
    chk("mid_level_after", 32'(bus.wr_level), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
